// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the decade counter, adder and display blocks.
package bcd_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic digitValid(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle of one counter stage; master drives, slave counts.
interface bcd_updown_counter_if #(
  parameter int N_DIGITS = 4
);
  import bcd_pkg::*;

  logic                          ei;
  logic                          up;
  logic                          load;
  logic [DIGIT_W*N_DIGITS-1:0]   din;
  logic [DIGIT_W*N_DIGITS-1:0]   q;
  logic                          eu;
  logic                          err;

  modport master (output ei, up, load, din, input q, eu, err);
  modport slave  (input ei, up, load, din, output q, eu, err);

endinterface

// File: rtl/bcd_digit_updown.sv
// One combinational decade digit: steps up or down when cin is set and
// reports carry/borrow when it crosses the 9/0 boundary.
module bcd_digit_updown
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] nd,
  output logic       cout
);

  always_comb begin
    nd = d;
    if (cin) begin
      if (up) begin
        nd = (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
      end else begin
        nd = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
      end
    end
  end

  assign cout = cin & (up ? (d == BCD_MAX) : (d == BCD_MIN));

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascadable N-digit BCD up/down counter with validated parallel load and
// selectable wrap or saturate behaviour at the all-9 / all-0 boundary.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  bcd_updown_counter_if.slave   bus
);

  localparam int W = DIGIT_W * N_DIGITS;

  logic [W-1:0]        q_q, q_d;
  logic                err_q, err_d;
  logic [W-1:0]        stepped;
  logic [N_DIGITS:0]   carry;
  logic                loadValid;
  logic                atBoundary;

  // The chain is seeded with 1 so it always holds the stepped value; ei only
  // decides whether that value is committed.
  assign carry[0] = 1'b1;

  for (genvar k = 0; k < N_DIGITS; k++) begin : gDigit
    bcd_digit_updown uDigit (
      .d    (q_q[DIGIT_W*k +: DIGIT_W]),
      .cin  (carry[k]),
      .up   (bus.up),
      .nd   (stepped[DIGIT_W*k +: DIGIT_W]),
      .cout (carry[k+1])
    );
  end

  assign atBoundary = carry[N_DIGITS];

  always_comb begin
    loadValid = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!digitValid(bus.din[DIGIT_W*k +: DIGIT_W])) begin
        loadValid = 1'b0;
      end
    end
  end

  // Saturating counters refuse the step that would cross the boundary.
  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (bus.load) begin
      if (loadValid) begin
        q_d = bus.din;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.ei) begin
      if (WRAP || !atBoundary) begin
        q_d = stepped;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.err = err_q;
  assign bus.eu  = bus.ei & ~bus.load & ~reset & atBoundary;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Exercises wrap, saturate and cascaded counter stages against a decimal model.
module tb_bcd_updown_counter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  bcd_updown_counter_if #(.N_DIGITS(4)) wBus ();
  bcd_updown_counter_if #(.N_DIGITS(4)) sBus ();
  bcd_updown_counter_if #(.N_DIGITS(2)) loBus ();
  bcd_updown_counter_if #(.N_DIGITS(2)) hiBus ();

  assign hiBus.ei = loBus.eu;

  bcd_updown_counter #(.N_DIGITS(4), .WRAP(1'b1)) uWrap (.clock(clock), .reset(reset), .bus(wBus));
  bcd_updown_counter #(.N_DIGITS(4), .WRAP(1'b0)) uSat  (.clock(clock), .reset(reset), .bus(sBus));
  bcd_updown_counter #(.N_DIGITS(2), .WRAP(1'b1)) uLo   (.clock(clock), .reset(reset), .bus(loBus));
  bcd_updown_counter #(.N_DIGITS(2), .WRAP(1'b1)) uHi   (.clock(clock), .reset(reset), .bus(hiBus));

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int stepVal(input int v, input bit up, input bit wrap);
    if (up) return (v == 9999) ? (wrap ? 0 : 9999) : v + 1;
    return (v == 0) ? (wrap ? 9999 : 0) : v - 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadW(input logic [15:0] v);
    wBus.load = 1'b1; wBus.din = v; wBus.ei = 1'b0;
    tick();
    wBus.load = 1'b0;
  endtask

  task automatic loadS(input logic [15:0] v);
    sBus.load = 1'b1; sBus.din = v; sBus.ei = 1'b0;
    tick();
    sBus.load = 1'b0;
  endtask

  task automatic test_reset();
    loadW(16'h4321);
    reset = 1'b1; wBus.load = 1'b1; wBus.din = 16'h12A4; wBus.ei = 1'b1; wBus.up = 1'b1;
    tick();
    vectors++;
    if (wBus.q !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_q: got %h expected 0000", wBus.q); end
    vectors++;
    if (wBus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", wBus.err); end
    wBus.din = 16'h1234; wBus.up = 1'b0;
    #1;
    vectors++;
    if (wBus.eu !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_eu: got %b expected 0", wBus.eu); end
    tick();
    vectors++;
    if (wBus.q !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_over_load: got %h expected 0000", wBus.q); end
    reset = 1'b0; wBus.load = 1'b0; wBus.ei = 1'b0;
  endtask

  task automatic test_up_ripple();
    loadW(16'h0999);
    wBus.ei = 1'b1; wBus.up = 1'b1;
    #1;
    vectors++;
    if (wBus.eu !== 1'b0) begin miscompares++; $display("[TB] FAIL up_ripple_eu: got %b expected 0", wBus.eu); end
    tick();
    wBus.ei = 1'b0;
    vectors++;
    if (wBus.q !== 16'h1000) begin miscompares++; $display("[TB] FAIL up_ripple_q: got %h expected 1000", wBus.q); end
    loadW(16'h9999);
    wBus.ei = 1'b1; wBus.up = 1'b1;
    #1;
    vectors++;
    if (wBus.eu !== 1'b1) begin miscompares++; $display("[TB] FAIL up_wrap_eu: got %b expected 1", wBus.eu); end
    tick();
    wBus.ei = 1'b0;
    vectors++;
    if (wBus.q !== 16'h0000) begin miscompares++; $display("[TB] FAIL up_wrap_q: got %h expected 0000", wBus.q); end
  endtask

  task automatic test_down_borrow();
    loadW(16'h1000);
    wBus.ei = 1'b1; wBus.up = 1'b0;
    tick();
    wBus.ei = 1'b0;
    vectors++;
    if (wBus.q !== 16'h0999) begin miscompares++; $display("[TB] FAIL down_borrow_q: got %h expected 0999", wBus.q); end
    loadW(16'h0000);
    wBus.ei = 1'b1; wBus.up = 1'b0;
    #1;
    vectors++;
    if (wBus.eu !== 1'b1) begin miscompares++; $display("[TB] FAIL down_wrap_eu: got %b expected 1", wBus.eu); end
    tick();
    wBus.ei = 1'b0;
    vectors++;
    if (wBus.q !== 16'h9999) begin miscompares++; $display("[TB] FAIL down_wrap_q: got %h expected 9999", wBus.q); end
  endtask

  task automatic test_saturate();
    logic expEu;
    for (int dir = 0; dir < 2; dir++) begin
      loadS(dir == 0 ? 16'h9998 : 16'h0001);
      sBus.ei = 1'b1; sBus.up = (dir == 0);
      for (int c = 0; c < 3; c++) begin
        expEu = (c != 0);
        #1;
        vectors++;
        if (sBus.eu !== expEu) begin miscompares++; $display("[TB] FAIL sat_eu dir=%0d cyc=%0d: got %b expected %b", dir, c, sBus.eu, expEu); end
        tick();
        vectors++;
        if (sBus.q !== (dir == 0 ? 16'h9999 : 16'h0000)) begin miscompares++; $display("[TB] FAIL sat_q dir=%0d cyc=%0d: got %h", dir, c, sBus.q); end
      end
      sBus.ei = 1'b0;
    end
  endtask

  task automatic test_load_validation();
    loadW(16'h0042);
    wBus.load = 1'b1; wBus.din = 16'h12A4; wBus.ei = 1'b1; wBus.up = 1'b1;
    tick();
    wBus.load = 1'b0; wBus.ei = 1'b0;
    vectors++;
    if (wBus.q !== 16'h0042) begin miscompares++; $display("[TB] FAIL bad_load_q: got %h expected 0042", wBus.q); end
    vectors++;
    if (wBus.err !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_load_err: got %b expected 1", wBus.err); end
    tick();
    vectors++;
    if (wBus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_one_cycle: got %b expected 0", wBus.err); end
    wBus.load = 1'b1; wBus.din = 16'h5678; wBus.ei = 1'b1;
    tick();
    wBus.load = 1'b0; wBus.ei = 1'b0;
    vectors++;
    if (wBus.q !== 16'h5678) begin miscompares++; $display("[TB] FAIL load_over_count: got %h expected 5678", wBus.q); end
    vectors++;
    if (wBus.err !== 1'b0) begin miscompares++; $display("[TB] FAIL good_load_err: got %b expected 0", wBus.err); end
  endtask

  task automatic test_random_main();
    int          valW, valS, loadVal, k;
    bit          doReset, doLoad, valid, ei, up;
    logic        expErr, expEuW, expEuS;
    logic [15:0] din;
    valW = 0; valS = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      doReset = ($urandom_range(0, 31) == 0);
      doLoad  = ($urandom_range(0, 5) == 0);
      ei      = 1'($urandom_range(0, 1));
      up      = 1'($urandom_range(0, 1));
      loadVal = int'($urandom_range(0, 9999));
      din     = toBcd(loadVal);
      valid   = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(0, 3));
        din[4*k +: 4] = 4'($urandom_range(10, 15));
        valid = 1'b0;
      end
      reset = doReset;
      wBus.load = doLoad; wBus.din = din; wBus.ei = ei; wBus.up = up;
      sBus.load = doLoad; sBus.din = din; sBus.ei = ei; sBus.up = up;
      expEuW = ei & !doLoad & !doReset & (up ? (valW == 9999) : (valW == 0));
      expEuS = ei & !doLoad & !doReset & (up ? (valS == 9999) : (valS == 0));
      #1;
      vectors++;
      if (wBus.eu !== expEuW) begin miscompares++; $display("[TB] FAIL rnd_wrap_eu step=%0d: got %b expected %b", i, wBus.eu, expEuW); end
      vectors++;
      if (sBus.eu !== expEuS) begin miscompares++; $display("[TB] FAIL rnd_sat_eu step=%0d: got %b expected %b", i, sBus.eu, expEuS); end
      tick();
      expErr = 1'b0;
      if (doReset) begin
        valW = 0; valS = 0;
      end else if (doLoad) begin
        if (valid) begin valW = loadVal; valS = loadVal; end
        expErr = !valid;
      end else if (ei) begin
        valW = stepVal(valW, up, 1'b1);
        valS = stepVal(valS, up, 1'b0);
      end
      vectors++;
      if (wBus.q !== toBcd(valW)) begin miscompares++; $display("[TB] FAIL rnd_wrap_q step=%0d: got %h expected %h", i, wBus.q, toBcd(valW)); end
      vectors++;
      if (sBus.q !== toBcd(valS)) begin miscompares++; $display("[TB] FAIL rnd_sat_q step=%0d: got %h expected %h", i, sBus.q, toBcd(valS)); end
      vectors++;
      if (wBus.err !== expErr || sBus.err !== expErr) begin
        miscompares++; $display("[TB] FAIL rnd_err step=%0d: got %b/%b expected %b", i, wBus.err, sBus.err, expErr);
      end
    end
    reset = 1'b0; wBus.load = 1'b0; wBus.ei = 1'b0; sBus.load = 1'b0; sBus.ei = 1'b0;
  endtask

  task automatic test_cascade();
    int          val, loadVal;
    bit          doLoad, ei, up;
    logic        expEu;
    logic [15:0] t;
    loBus.load = 1'b1; hiBus.load = 1'b1; loBus.din = 8'h99; hiBus.din = 8'h00; loBus.ei = 1'b0;
    tick();
    loBus.load = 1'b0; hiBus.load = 1'b0;
    loBus.ei = 1'b1; loBus.up = 1'b1; hiBus.up = 1'b1;
    #1;
    vectors++;
    if (loBus.eu !== 1'b1) begin miscompares++; $display("[TB] FAIL cascade_lo_eu: got %b expected 1", loBus.eu); end
    tick();
    loBus.ei = 1'b0;
    vectors++;
    if ({hiBus.q, loBus.q} !== 16'h0100) begin miscompares++; $display("[TB] FAIL cascade_step: got %h expected 0100", {hiBus.q, loBus.q}); end
    val = 100;
    for (int i = 0; i < 200; i++) begin
      doLoad  = ($urandom_range(0, 9) == 0);
      ei      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom_range(0, 1));
      loadVal = ($urandom_range(0, 3) == 0) ? ((up == 1'b1) ? 9999 : 0) : int'($urandom_range(0, 9999));
      t       = toBcd(loadVal);
      loBus.load = doLoad; hiBus.load = doLoad;
      loBus.din = t[7:0]; hiBus.din = t[15:8];
      loBus.ei = ei; loBus.up = up; hiBus.up = up;
      expEu = ei & !doLoad & (up ? (val == 9999) : (val == 0));
      #1;
      vectors++;
      if (hiBus.eu !== expEu) begin miscompares++; $display("[TB] FAIL cascade_eu step=%0d: got %b expected %b", i, hiBus.eu, expEu); end
      tick();
      if (doLoad) val = loadVal;
      else if (ei) val = stepVal(val, up, 1'b1);
      t = toBcd(val);
      vectors++;
      if ({hiBus.q, loBus.q} !== t) begin miscompares++; $display("[TB] FAIL cascade_q step=%0d: got %h expected %h", i, {hiBus.q, loBus.q}, t); end
    end
    loBus.load = 1'b0; hiBus.load = 1'b0; loBus.ei = 1'b0;
  endtask

  initial begin
    wBus.ei = 1'b0; wBus.up = 1'b0; wBus.load = 1'b0; wBus.din = '0;
    sBus.ei = 1'b0; sBus.up = 1'b0; sBus.load = 1'b0; sBus.din = '0;
    loBus.ei = 1'b0; loBus.up = 1'b0; loBus.load = 1'b0; loBus.din = '0;
    hiBus.up = 1'b0; hiBus.load = 1'b0; hiBus.din = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    $display("[TB] starting bcd_updown_counter checks");
    test_reset();
    test_up_ripple();
    test_down_borrow();
    test_saturate();
    test_load_validation();
    test_random_main();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit base-10 counter that generalises the single-digit up counter.
- Adds N-digit width, up/down direction, synchronous parallel load with BCD validation, and a selectable wrap or saturate mode.
- Used as the decade-counting building block for timers, event counters and display drivers.
- Cascadable through the ei/eu enable chain.

Parameters:
- N_DIGITS, 4, number of BCD digits; legal range 1..8.
- WRAP, 1, 1 = wrap at the boundary (9..9 -> 0..0 up, 0..0 -> 9..9 down); 0 = saturate and hold at the boundary.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- ei  in  1  count enable / carry-borrow in from a lower stage.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled with ei.
- load  in  1  synchronous parallel load request.
- din  in  4*N_DIGITS  load value; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- q  out  4*N_DIGITS  registered count value, same digit packing as din.
- eu  out  1  combinational carry/borrow out to the next stage.
- err  out  1  registered one-cycle flag for a rejected load.

Behaviour:
- Reset: on posedge clock with reset=1, q <= 0 and err <= 0. Reset overrides load and ei. Asserting reset mid-count takes effect at that edge with no partial update.
- Priority at each posedge: reset > load > count (ei=1) > hold.
- Load, all digits valid (every nibble of din <= 9): q <= din and err <= 0. ei is ignored in that cycle.
- Load, any nibble > 9: q holds and err <= 1 for exactly one cycle. No count occurs in that cycle even if ei=1.
- err is 0 in every cycle not caused by a rejected load.
- Count: with ei=1, load=0, reset=0, q becomes q±1 in decimal on the next posedge. Latency is 1 clock.
- Up carry chain: digit k increments iff ei and all lower digits are 9. A digit at 9 wraps to 0 and propagates.
- Down borrow chain: digit k decrements iff ei and all lower digits are 0. A digit at 0 becomes 9 and propagates.
- eu = ei & ~load & ~reset & (up ? all digits 9 : all digits 0).
  - eu is combinational, identical in timing to the single-digit counter's carry, so a higher stage counts in the same edge.
- Boundary with WRAP=1: up at 9..9 -> 0..0 with eu=1; down at 0..0 -> 9..9 with eu=1.
- Boundary with WRAP=0: q holds at 9..9 (up) or 0..0 (down). eu is still asserted, so an external stage can detect the overflow.
- Direction change is legal every cycle; no state depends on the previous direction.
- q never holds a non-BCD nibble. This is guaranteed by load validation and by the digit arithmetic.
- No internal state machine beyond the q register and the err register. The design is fully synchronous with no combinational path from q to reset.

Decomposition:
- Shared package (bcd_pkg): BCD_MAX = 4'd9, BCD_MIN = 4'd0, DIGIT_W = 4, and a digit-valid function (nibble <= 9). The package is reused by the adder and display blocks.
- Sub-module bcd_digit_updown: purely combinational, one instance per digit through a generate loop.
  - Inputs: d[3:0], cin, up.
  - Outputs: nd[3:0], cout.
  - cout = cin & (up ? d==9 : d==0).
- The top level holds the registers, load validation, priority logic, saturate gating and the eu derivation.

Test Plan:
- Run all scenarios with N_DIGITS=4, except scenario 6.
1. Reset: apply reset=1 for 1 cycle with q arbitrary -> q=0000 and err=0 after the edge. With reset=1 and load=1, din=1234 -> q=0000.
2. Up ripple, WRAP=1: load 0999, then ei=1, up=1 for 1 cycle -> q=1000, eu=0. Load 9999, up with ei=1 -> eu=1 before the edge and q=0000 after it.
3. Down borrow, WRAP=1: load 1000, ei=1, up=0 -> q=0999. Load 0000, down -> eu=1 and q=9999.
4. Saturate, WRAP=0: load 9998 and count up 3 cycles -> q=9999, 9999, 9999 with eu=1 in the last two cycles. Mirror the test at 0000 counting down.
5. Load validation: load=1, din=12A4 (nibble 0xA) with q=0042 -> q stays 0042, err=1 for one cycle, then err=0. Then load=1, ei=1, din=5678 -> q=5678 with no increment.
6. Cascade with two N_DIGITS=2 instances, eu of the low stage to ei of the high stage: from 0099 with up, one edge -> high:low = 01:00. Then 200 random up/down steps against a decimal reference model.
